// File: rtl/uart_apb_rx_regs.sv
// APB-mapped receive FIFO for a UART: buffers bytes from the receive stage
// and exposes DATA / STATUS / CTRL / CLR registers plus a level interrupt.
module uart_apb_rx_regs #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_CLR    = 2'd3;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_en;
  logic          r_ie;
  logic          r_under;
  logic          r_irq;

  logic          w_access;
  logic [1:0]    w_addr;
  logic          w_ne;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_under_set;
  logic          w_under_clr;
  logic          w_ctrl_wr;
  logic [31:0]   w_status;

  assign w_access = psel & penable;
  assign w_addr   = paddr[3:2];
  assign w_ne     = (r_count != '0);
  assign w_full   = (r_count == CW'(DEPTH));

  assign rx_ready = r_en & ~w_full;
  assign w_push   = rx_valid & rx_ready;

  assign w_pop       = w_access & ~pwrite & (w_addr == A_DATA) & w_ne;
  assign w_under_set = w_access & ~pwrite & (w_addr == A_DATA) & ~w_ne;
  assign w_flush     = w_access &  pwrite & (w_addr == A_CLR) & pwdata[0];
  assign w_under_clr = w_access &  pwrite & (w_addr == A_CLR) & pwdata[2];
  assign w_ctrl_wr   = w_access &  pwrite & (w_addr == A_CTRL);

  assign w_status = {23'b0, 5'(r_count), 1'b0, r_under, w_full, w_ne};

  assign pready  = 1'b1;
  assign irq     = r_irq;
  // Error response is suppressed while reset is held.
  assign pslverr = rstn & w_access &
                   ((pwrite & ((w_addr == A_DATA) | (w_addr == A_STATUS))) |
                    (~pwrite & (w_addr == A_CLR)));

  // Read mux; returns zero outside a selected read.
  always_comb begin
    prdata = '0;
    if (psel & ~pwrite) begin
      case (w_addr)
        A_DATA:   prdata = w_ne ? {24'b0, r_mem[r_rptr]} : '0;
        A_STATUS: prdata = w_status;
        A_CTRL:   prdata = {30'b0, r_ie, r_en};
        default:  prdata = '0;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= rx_data;
  end

  // Pointers and occupancy; a flush overrides any concurrent push or pop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Control, sticky underflow and the interrupt, which lags status by a cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_en    <= 1'b0;
      r_ie    <= 1'b0;
      r_under <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_ctrl_wr) begin
        r_en <= pwdata[0];
        r_ie <= pwdata[1];
      end
      if (w_under_set)      r_under <= 1'b1;
      else if (w_under_clr) r_under <= 1'b0;
      r_irq <= r_ie & (w_ne | r_under);
    end
  end

endmodule

// File: tb/tb_uart_apb_rx_regs.sv
// Directed bench for uart_apb_rx_regs with a byte scoreboard queue.
module tb_uart_apb_rx_regs;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  sb [$];

  uart_apb_rx_regs #(.DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_rd(input logic [3:0] a, output logic [31:0] d, output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    d = prdata; e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic apb_wr(input logic [3:0] a, input logic [31:0] v, output logic e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = v;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    e = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    logic acc;
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = d;
    acc = rx_ready;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (acc) sb.push_back(d);
  endtask

  // DATA read compared against the scoreboard head (zero when empty).
  task automatic data_rd(input string tag);
    logic [31:0] d;
    logic        e;
    logic [31:0] exp;
    exp = (sb.size() > 0) ? {24'b0, sb.pop_front()} : 32'h0;
    apb_rd(4'h0, d, e);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    rstn = 1'b0; rx_data = '0; rx_valid = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_ready", 32'(rx_ready), 32'h0);
    chk("rst_pready", 32'(pready), 32'h1);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    rstn = 1'b1;

    // Single byte round trip
    apb_wr(4'h8, 32'h1, e);
    chk("ctrl_wr_err", 32'(e), 32'h0);
    push_byte(8'hA5);
    apb_rd(4'h4, d, e);
    chk("status_one", d, 32'h011);
    data_rd("data_a5");
    apb_rd(4'h4, d, e);
    chk("status_empty", d, 32'h000);

    // Fill to DEPTH, then drain in order
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    #1;
    chk("full_rx_ready", 32'(rx_ready), 32'h0);
    push_byte(8'hEE);
    chk("full_sb_size", 32'(sb.size()), 32'd8);
    apb_rd(4'h4, d, e);
    chk("status_full", d, 32'h083);
    data_rd("drain_0");
    chk("ready_after_pop", 32'(rx_ready), 32'h1);
    for (int i = 1; i < 8; i++) data_rd($sformatf("drain_%0d", i));

    // Underflow with interrupts enabled
    apb_wr(4'h8, 32'h3, e);
    data_rd("data_empty");
    apb_rd(4'h4, d, e);
    chk("status_under", d, 32'h004);
    chk("irq_under", 32'(irq), 32'h1);
    apb_wr(4'hC, 32'h4, e);
    chk("irq_lag", 32'(irq), 32'h1);
    @(posedge clk); #1;
    chk("irq_cleared", 32'(irq), 32'h0);
    apb_rd(4'h4, d, e);
    chk("status_clr", d, 32'h000);

    // Simultaneous push and pop at count 3
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 4'h0;
    @(posedge clk); #1;
    penable = 1'b1; rx_valid = 1'b1; rx_data = 8'h44;
    #1;
    chk("pp_rdata", prdata, {24'b0, sb.pop_front()});
    if (rx_ready) sb.push_back(8'h44);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; rx_valid = 1'b0;
    apb_rd(4'h4, d, e);
    chk("pp_status", d, 32'h031);
    for (int i = 0; i < 3; i++) data_rd($sformatf("pp_order_%0d", i));

    // Error responses leave state untouched
    apb_wr(4'h4, 32'h0, e);
    chk("err_wr_status", 32'(e), 32'h1);
    apb_rd(4'h8, d, e);
    chk("ctrl_kept", d, 32'h3);
    apb_rd(4'hC, d, e);
    chk("err_rd_clr", 32'(e), 32'h1);
    chk("clr_rd_zero", d, 32'h0);

    // Flush wins over a concurrent push
    push_byte(8'h55);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'hC; pwdata = 32'h1;
    @(posedge clk); #1;
    penable = 1'b1; rx_valid = 1'b1; rx_data = 8'h66;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_valid = 1'b0;
    sb.delete();
    apb_rd(4'h4, d, e);
    chk("flush_status", d, 32'h000);

    // Disable stops acceptance
    apb_wr(4'h8, 32'h0, e);
    chk("dis_rx_ready", 32'(rx_ready), 32'h0);

    // Reset in the middle of a burst
    apb_wr(4'h8, 32'h3, e);
    push_byte(8'h77); push_byte(8'h78);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = 8'h79;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 4'h4;
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(rx_ready), 32'h0);
    chk("mid_rst_prdata", prdata, 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_slverr", 32'(pslverr), 32'h0);
    sb.delete();
    rx_valid = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    apb_rd(4'h4, d, e);
    chk("post_rst_status", d, 32'h000);
    apb_rd(4'h8, d, e);
    chk("post_rst_ctrl", d, 32'h000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_apb_rx_regs.md
UART_APB_RX_REGS -- requirements
Module: uart_apb_rx_regs

Interface
REQ-001 SHALL have parameter DEPTH, default 8, receive FIFO entry count; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  single clock; every flop on its rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rx_data  input  8  byte from the upstream UART receive stage.
REQ-005 SHALL have port rx_valid  input  1  rx_data holds a byte.
REQ-006 SHALL have port rx_ready  output  1  block accepts rx_data this cycle.
REQ-007 SHALL have port psel  input  1  APB select.
REQ-008 SHALL have port penable  input  1  APB access phase.
REQ-009 SHALL have port pwrite  input  1  APB write when 1.
REQ-010 SHALL have port paddr  input  4  APB byte address; bits [1:0] ignored.
REQ-011 SHALL have port pwdata  input  32  APB write data.
REQ-012 SHALL have port prdata  output  32  APB read data.
REQ-013 SHALL have port pready  output  1  APB ready.
REQ-014 SHALL have port pslverr  output  1  APB error.
REQ-015 SHALL have port irq  output  1  level interrupt request.

Function
REQ-016 SHALL implement a DEPTH-entry byte FIFO with read pointer, write pointer and count (width clog2(DEPTH)+1); pointers wrap modulo DEPTH.
REQ-017 SHALL drive rx_ready = CTRL.EN & (count != DEPTH), combinationally.
REQ-018 SHALL push rx_data on a clock edge with rx_valid & rx_ready; the byte is readable from the next cycle.
REQ-019 SHALL hold pready = 1 always (zero wait states); each transfer = setup cycle (psel & ~penable) then access cycle (psel & penable).
REQ-020 SHALL decode paddr[3:2]: 0 DATA (RO), 1 STATUS (RO), 2 CTRL (RW), 3 CLR (WO).
REQ-021 DATA read: prdata = {24'b0, head byte}; pop exactly once, at the end of the access cycle, only when count > 0.
REQ-022 DATA read while empty: prdata = 0, no pop, pslverr = 0, STATUS.UNDER set.
REQ-023 STATUS: bit0 NE (count != 0), bit1 FULL (count == DEPTH), bit2 UNDER (sticky), bits[8:4] count, others 0.
REQ-024 CTRL: bit0 EN, bit1 IE; other bits read 0; written from pwdata in the access cycle.
REQ-025 CLR write: pwdata bit0 = 1 flushes the FIFO (pointers and count to 0); bit2 = 1 clears UNDER; reads return 0.
REQ-026 SHALL assert pslverr in the access cycle for a write to DATA or STATUS or a read of CLR; the register state is unchanged.
REQ-027 prdata SHALL be valid in the access cycle and 0 outside psel.
REQ-028 Push and pop in the same cycle: count unchanged and both take effect; when full, a pop and a push in the same edge is not possible because rx_ready is already low.
REQ-029 Flush and push in the same cycle: flush wins and the pushed byte is discarded.
REQ-030 Clearing EN stops acceptance from the next cycle; FIFO contents are kept.
REQ-031 irq = CTRL.IE & (NE | UNDER), registered, so it is one cycle behind the status bits.

Reset
REQ-032 On rstn low, asynchronously: pointers, count, CTRL, UNDER and irq = 0.
REQ-033 During reset: rx_ready = 0, prdata = 0, pslverr = 0, pready = 1.
REQ-034 Reset in the middle of an operation discards all FIFO contents; there is no partial APB completion.

Verification
REQ-035 Enable then push 0xA5 -> STATUS reads 0x011; DATA reads 0x000000A5; STATUS then reads 0x000.
REQ-036 Push 8 bytes 0x01..0x08 with DEPTH=8 -> rx_ready=0 and STATUS=0x083; 8 DATA reads return 0x01..0x08 in order; rx_ready returns to 1 after the first pop.
REQ-037 DATA read while empty -> prdata=0, STATUS=0x004, irq=1 if IE=1; CLR write 0x4 -> STATUS=0x000 and irq=0 one cycle later.
REQ-038 Count=3 with a push and DATA pop on the same edge -> count stays 3 and order is preserved.
REQ-039 Write to STATUS -> pslverr=1 for that access cycle; CTRL is unchanged.
REQ-040 Assert rstn low in the middle of a burst -> outputs take their reset values immediately and STATUS reads 0 after release.
